// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronises, debounces and checks six tank/irrigation sensor inputs.
// Optional tank consistency monitor built when SENSOR_FAULT_EN is defined. Rev 1.0
`default_nettype none

module sensor_conditioner #(
  parameter int TICK_DIV    = 50000,
  parameter int DEB_COUNT   = 20,
  parameter int FAULT_COUNT = 200
) (
  input  logic       clk,
  input  logic       rest,
  input  logic [5:0] raw_in,
  input  logic       fault_clr,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       Ua,
  output logic       Us,
  output logic       T,
  output logic       ready,
  output logic       upd,
  output logic       sens_fault
);

  localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_DW = $clog2(DEB_COUNT + 1);
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_DW-1:0] c_DEB_LAST   = c_DW'(DEB_COUNT - 1);

  logic [5:0]      r_sync1;
  logic [5:0]      r_sync2;
  logic [c_PW-1:0] r_presc;
  logic [c_DW-1:0] r_rdy_cnt;
  logic            r_ready;
  logic            r_upd;
  logic            w_tick;
  logic [5:0]      w_out;
  logic [5:0]      w_toggle;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A channel output only moves after DEB_COUNT consecutive mismatching ticks.
  for (genvar g = 0; g < 6; g++) begin : g_chan
    logic [c_DW-1:0] r_cnt;
    logic            r_q;

    assign w_toggle[g] = w_tick && (r_sync2[g] != r_q) && (r_cnt == c_DEB_LAST);
    assign w_out[g]    = r_q;

    always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
        r_cnt <= '0;
        r_q   <= 1'b0;
      end else if (w_tick) begin
        if (r_sync2[g] == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_q   <= r_sync2[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_upd     <= 1'b0;
      r_rdy_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_upd <= |w_toggle;
      if (w_tick && !r_ready) begin
        if (r_rdy_cnt == c_DEB_LAST) begin
          r_ready <= 1'b1;
        end else begin
          r_rdy_cnt <= r_rdy_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SENSOR_FAULT_EN
  localparam int c_FW = $clog2(FAULT_COUNT + 1);
  localparam logic [c_FW-1:0] c_FAULT_MAX  = c_FW'(FAULT_COUNT);
  localparam logic [c_FW-1:0] c_FAULT_LAST = c_FW'(FAULT_COUNT - 1);

  logic [c_FW-1:0] r_fcnt;
  logic            r_fault;
  logic            w_incons;
  logic            w_fset;

  // A higher level sensor wet while a lower one is dry cannot happen physically.
  assign w_incons = (w_out[5] & ~w_out[4]) | (w_out[4] & ~w_out[3]);
  assign w_fset   = w_tick && w_incons && (r_fcnt == c_FAULT_LAST);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_fcnt  <= '0;
      r_fault <= 1'b0;
    end else if (w_fset) begin
      r_fcnt  <= c_FAULT_MAX;
      r_fault <= 1'b1;
    end else if (fault_clr) begin
      r_fcnt  <= '0;
      r_fault <= 1'b0;
    end else if (w_tick) begin
      if (!w_incons) begin
        r_fcnt <= '0;
      end else if (r_fcnt != c_FAULT_MAX) begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign sens_fault = r_fault;
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
  assign sens_fault         = 1'b0;
`endif

  assign {H, M, L, Ua, Us, T} = w_out;
  assign ready = r_ready;
  assign upd   = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed checks of sensor_conditioner with TICK_DIV=4, DEB_COUNT=3, FAULT_COUNT=5.
`default_nettype none

module tb_sensor_conditioner;

`ifdef SENSOR_FAULT_EN
  localparam logic FAULT_ON = 1'b1;
`else
  localparam logic FAULT_ON = 1'b0;
`endif

  logic       clk;
  logic       rest;
  logic [5:0] raw_in;
  logic       fault_clr;
  logic       H, M, L, Ua, Us, T;
  logic       ready, upd, sens_fault;
  logic [5:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;
  int base  = 0;

  sensor_conditioner #(
    .TICK_DIV   (4),
    .DEB_COUNT  (3),
    .FAULT_COUNT(5)
  ) dut (
    .clk       (clk),
    .rest      (rest),
    .raw_in    (raw_in),
    .fault_clr (fault_clr),
    .H         (H),
    .M         (M),
    .L         (L),
    .Ua        (Ua),
    .Us        (Us),
    .T         (T),
    .ready     (ready),
    .upd       (upd),
    .sens_fault(sens_fault)
  );

  assign outs = {H, M, L, Ua, Us, T};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since the last reset release; ticks land on multiples of 4.
  always @(posedge clk) if (rest) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_after(input int k);
    int guard;
    guard = 0;
    while (ecnt < k) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        n_bad++;
        $display("FAIL timeout waiting for edge %0d: observed=%0d expected=%0d", k, ecnt, k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "edge wait expired");
      end
    end
  endtask

  initial begin
    rest      = 1'b0;
    raw_in    = 6'b111000;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'd0, outs}, 32'h0);
    chk("rst_ready", {31'd0, ready}, 32'h0);
    chk("rst_upd", {31'd0, upd}, 32'h0);
    chk("rst_fault", {31'd0, sens_fault}, 32'h0);
    rest = 1'b1;

    to_after(8);
    chk("ready_early", {31'd0, ready}, 32'h0);
    to_after(11);
    chk("hml_before", {26'd0, outs}, 32'h0);
    chk("ready_before", {31'd0, ready}, 32'h0);
    to_after(12);
    chk("hml_rise", {26'd0, outs}, {26'd0, 6'b111000});
    chk("ready_rise", {31'd0, ready}, 32'h1);
    chk("upd_hml", {31'd0, upd}, 32'h1);

    // Two short Ua pulses; a counter that failed to clear would toggle on the second.
    raw_in = 6'b111100;
    for (int k = 13; k <= 47; k++) begin
      to_after(k);
      chk("ua_glitch", {31'd0, Ua}, 32'h0);
      chk("upd_quiet", {31'd0, upd}, 32'h0);
      chk("fault_quiet", {31'd0, sens_fault}, 32'h0);
      if (k == 20) raw_in = 6'b111000;
      if (k == 24) raw_in = 6'b111100;
      if (k == 32) raw_in = 6'b111000;
      if (k == 36) raw_in = 6'b100000;
    end
    chk("hml_hold", {26'd0, outs}, {26'd0, 6'b111000});

    to_after(48);
    chk("ml_fall", {26'd0, outs}, {26'd0, 6'b100000});
    chk("upd_ml", {31'd0, upd}, 32'h1);
    to_after(49);
    chk("upd_one", {31'd0, upd}, 32'h0);
    to_after(67);
    chk("fault_before", {31'd0, sens_fault}, 32'h0);
    to_after(68);
    chk("fault_set", {31'd0, sens_fault}, {31'd0, FAULT_ON});

    raw_in = 6'b111000;
    to_after(79);
    chk("ml_low", {26'd0, outs}, {26'd0, 6'b100000});
    to_after(80);
    chk("ml_back", {26'd0, outs}, {26'd0, 6'b111000});
    chk("upd_back", {31'd0, upd}, 32'h1);
    to_after(85);
    chk("fault_sticky", {31'd0, sens_fault}, {31'd0, FAULT_ON});
    fault_clr = 1'b1;
    to_after(86);
    chk("fault_clr", {31'd0, sens_fault}, 32'h0);
    fault_clr = 1'b0;

    raw_in = 6'b111001;
    to_after(96);
    chk("t_pending", {26'd0, outs}, {26'd0, 6'b111000});
    #2 rest = 1'b0;
    #1;
    chk("async_outs", {26'd0, outs}, 32'h0);
    chk("async_ready", {31'd0, ready}, 32'h0);
    chk("async_upd", {31'd0, upd}, 32'h0);
    chk("async_fault", {31'd0, sens_fault}, 32'h0);
    repeat (3) @(negedge clk);
    base = ecnt;
    rest = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      to_after(base + j);
      chk("t_restart", {31'd0, T}, 32'h0);
      chk("ready_restart", {31'd0, ready}, 32'h0);
    end
    to_after(base + 12);
    chk("t_rise", {26'd0, outs}, {26'd0, 6'b111001});
    chk("ready_again", {31'd0, ready}, 32'h1);
    chk("upd_t", {31'd0, upd}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per sample tick (1 ms at 50 MHz); legal range >=2.
REQ-002 The block SHALL have parameter DEB_COUNT, default 20, meaning consecutive mismatching ticks required to accept a new input level; legal range 1..255.
REQ-003 The block SHALL have parameter FAULT_COUNT, default 200, meaning consecutive inconsistent ticks required to raise a level fault; legal range 1..65535.
REQ-004 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port: rest  input  1  reset, asynchronous, active-low.
REQ-006 Port: raw_in  input  6  unsynchronised sensors {H,M,L,Ua,Us,T}, bit 5 = H down to bit 0 = T.
REQ-007 Port: fault_clr  input  1  synchronous, level-sensitive clear of sens_fault.
REQ-008 Port: H, M, L, Ua, Us, T  output  1 each  debounced sensor levels that drive the irrigation and level controllers.
REQ-009 Port: ready  output  1  high once outputs reflect a full debounce window after reset.
REQ-010 Port: upd  output  1  one-cycle pulse when any debounced output changes.
REQ-011 Port: sens_fault  output  1  sticky tank-sensor inconsistency flag.

Function
REQ-012 Each raw_in bit SHALL pass through a two-flop synchroniser before any other logic, giving 2 cycles of input latency.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 and SHALL assert an internal tick for one cycle when the count is TICK_DIV-1, then wrap to 0.
REQ-014 Each of the six channels SHALL own a counter of width clog2(DEB_COUNT+1).
REQ-015 On a tick where the synchronised bit differs from its output, the channel counter SHALL increment.
REQ-016 On a tick where the synchronised bit equals its output, the channel counter SHALL clear to 0, so a glitch shorter than DEB_COUNT ticks is discarded.
REQ-017 On the tick where the counter would reach DEB_COUNT, the output SHALL toggle to the synchronised value and the counter SHALL clear to 0.
REQ-018 Non-tick cycles SHALL leave all counters and outputs unchanged.
REQ-019 Channels SHALL be independent; simultaneous changes on several channels SHALL update in the same cycle.
REQ-020 upd SHALL be high in the cycle following any output toggle, for exactly one cycle, however many channels toggle together.
REQ-021 A ready counter SHALL count ticks after reset, and ready SHALL rise on the DEB_COUNT-th tick and stay high until reset.
REQ-022 A tank reading SHALL be inconsistent when (H & ~M) | (M & ~L) on the debounced outputs.
REQ-023 A fault counter of width clog2(FAULT_COUNT+1) SHALL increment on each tick with an inconsistent reading and clear on a tick with a consistent reading.
REQ-024 On reaching FAULT_COUNT, the fault counter SHALL set sens_fault, saturate, and hold.
REQ-025 sens_fault SHALL remain set until fault_clr is sampled high or reset occurs.
REQ-026 If fault_clr and a set condition coincide in the same cycle, set SHALL win.
REQ-027 fault_clr SHALL also clear the fault counter.

Reset
REQ-028 While rest=0, H, M, L, Ua, Us, T, ready, upd and sens_fault SHALL be 0, and the prescaler, all counters and synchroniser flops SHALL be 0.
REQ-029 An asserting edge of rest SHALL take effect immediately, without a clock edge, including mid-debounce and mid-fault count.
REQ-030 Deassertion of rest SHALL restart the prescaler from 0.

Configuration
REQ-031 With macro SENSOR_FAULT_EN defined, the consistency monitor of REQ-022..REQ-027 SHALL be built.
REQ-032 Without SENSOR_FAULT_EN, the fault counter SHALL be absent, sens_fault SHALL be tied to 0, and fault_clr SHALL be ignored.

Verification (TICK_DIV=4, DEB_COUNT=3, FAULT_COUNT=5, SENSOR_FAULT_EN defined)
REQ-033 Reset, then raw_in=6'b111000 held: H, M and L SHALL rise together 2 sync cycles plus 3 ticks later (<=14 cycles), with a single upd pulse, and ready SHALL be 1 from the 3rd tick.
REQ-034 Ua pulsed high for 2 ticks then low: Ua SHALL stay 0, upd SHALL stay 0, and the Ua counter SHALL return to 0.
REQ-035 raw_in=6'b100000 (H without M/L) held: after debounce, sens_fault SHALL set 5 ticks later.
REQ-036 With the sens_fault condition of REQ-035 cleared: sens_fault SHALL persist until fault_clr=1 for one cycle, then drop.
REQ-037 rest pulsed low mid-count with a toggle pending on T: all outputs SHALL go 0 asynchronously, and the toggle SHALL require a full 3 fresh ticks after release.
REQ-038 Build without SENSOR_FAULT_EN and apply the stimulus of REQ-035: sens_fault SHALL stay 0 throughout.
